htree_read_return_16: RTL and testbench

- Read-return half of the 16-leaf H-tree memory fabric.
- Collects `data_out` from the 16 subarrays through a registered 16→4→1 reduction tree. This mirrors the forward path: group select is `addr[11:10]`, leaf-in-group select is `addr[9:8]`.
- Checks each return against an in-order queue of issued reads and presents one root read port.
- Sits beside the forward distribution tree; the root controller pushes the leaf ID of every read it issues.

---
 rtl/htree_pkg.sv | 28 ++
 rtl/htree_rd_fifo.sv | 54 +++++
 rtl/htree_read_return_16.sv | 161 ++++++++++++++++
 tb/tb_htree_read_return_16.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/htree_pkg.sv
// Shared constants, leaf ID type and the 4:1 encode/collision helper used at both tree levels.
package htree_pkg;

    localparam int unsigned LEAVES = 16;
    localparam int unsigned GROUPS = 4;
    localparam int unsigned LEAF_W = 4;

    typedef logic [LEAF_W-1:0] leaf_id_t;

    typedef struct packed {
        logic       any;
        logic       multi;
        logic [1:0] idx;
    } enc4_t;

    // idx is only meaningful when exactly one input is set
    function automatic enc4_t enc4(input logic [3:0] v);
        enc4_t r;
        r.any   = |v;
        r.multi = (v & (v - 4'd1)) != 4'd0;
        r.idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) r.idx = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/htree_rd_fifo.sv
// Pending-read queue: circular buffer with count, full and empty flags.
module htree_rd_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [Width-1:0]       i_wdata,
    output logic [Width-1:0]       o_rdata,
    output logic [$clog2(Depth):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [PtrW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PtrW+1)'(Depth));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    // Depth is a power of two, so pointer overflow wraps modulo Depth
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/htree_read_return_16.sv
// Read-return tree: 16->4->1 registered OR reduction, checked against the in-order pending queue.
// Optional watchdog enabled by defining HTREE_RD_TIMEOUT_EN.
module htree_read_return_16
    import htree_pkg::*;
#(
    parameter int unsigned BusWidth       = 32,
    parameter int unsigned ReqDepth       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         req_valid,
    input  logic [LEAF_W-1:0]            req_leaf,
    output logic                         req_ready,
    input  logic [LEAVES-1:0]            rd_valid_sub,
    input  logic [LEAVES*BusWidth-1:0]   data_out_sub,
    output logic [BusWidth-1:0]          data_out,
    output logic                         data_out_valid,
    output logic [LEAF_W-1:0]            data_out_leaf,
    output logic [$clog2(ReqDepth):0]    pending,
    output logic                         err_collision,
    output logic                         err_unexpected,
    output logic                         err_timeout
);

    logic [GROUPS-1:0]                r_gv, w_gv;
    logic [GROUPS-1:0]                r_gm, w_gm;
    logic [GROUPS-1:0][1:0]           r_gl, w_gl;
    logic [GROUPS-1:0][BusWidth-1:0]  r_gd, w_gd;

    enc4_t                            w_renc;
    logic [BusWidth-1:0]              w_rd, r_rd;
    leaf_id_t                         w_rl, r_rl;
    logic                             w_rm, r_rm, r_rv;

    logic                             r_dv, r_col, r_unx;
    logic [BusWidth-1:0]              r_data;
    leaf_id_t                         r_leaf;

    leaf_id_t                         w_head;
    logic                             w_full, w_empty, w_hit, w_pop;

    always_comb begin : p_stage1
        enc4_t l_enc;
        w_gv = '0;
        w_gm = '0;
        w_gl = '0;
        w_gd = '0;
        for (int g = 0; g < GROUPS; g++) begin
            l_enc   = enc4(rd_valid_sub[4*g +: 4]);
            w_gv[g] = l_enc.any;
            w_gm[g] = l_enc.multi;
            w_gl[g] = l_enc.idx;
            for (int l = 0; l < 4; l++) begin
                if (rd_valid_sub[4*g+l]) begin
                    w_gd[g] = w_gd[g] | data_out_sub[(4*g+l)*BusWidth +: BusWidth];
                end
            end
        end
    end

    always_comb begin : p_stage2
        w_renc = enc4(r_gv);
        w_rd   = '0;
        for (int g = 0; g < GROUPS; g++) begin
            if (r_gv[g]) w_rd = w_rd | r_gd[g];
        end
        w_rl = {w_renc.idx, r_gl[w_renc.idx]};
        w_rm = (|r_gm) | w_renc.multi;
    end

    // Return is accepted only when it names the oldest outstanding read
    assign w_hit = r_rv & ~r_rm & ~w_empty & (r_rl == w_head);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_gv   <= '0;
            r_gm   <= '0;
            r_gl   <= '0;
            r_gd   <= '0;
            r_rv   <= 1'b0;
            r_rm   <= 1'b0;
            r_rl   <= '0;
            r_rd   <= '0;
            r_dv   <= 1'b0;
            r_col  <= 1'b0;
            r_unx  <= 1'b0;
            r_data <= '0;
            r_leaf <= '0;
        end else begin
            r_gv   <= w_gv;
            r_gm   <= w_gm;
            r_gl   <= w_gl;
            r_gd   <= w_gd;
            r_rv   <= w_renc.any;
            r_rm   <= w_rm;
            r_rl   <= w_rl;
            r_rd   <= w_rd;
            r_dv   <= w_hit;
            r_col  <= r_rv & r_rm;
            r_unx  <= r_rv & ~r_rm & ~w_hit;
            if (w_hit) begin
                r_data <= r_rd;
                r_leaf <= r_rl;
            end
        end
    end

`ifdef HTREE_RD_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

    logic [ToW-1:0] r_tcnt;
    logic           r_to;
    logic           w_to_hit;

    // An accepted return in the same cycle takes priority over the watchdog
    assign w_to_hit = ~w_empty & ~w_hit & (r_tcnt == ToW'(TIMEOUT_CYCLES - 1));
    assign w_pop    = w_hit | w_to_hit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tcnt <= '0;
            r_to   <= 1'b0;
        end else begin
            r_to <= w_to_hit;
            if (w_empty || w_pop) r_tcnt <= '0;
            else                  r_tcnt <= r_tcnt + 1'b1;
        end
    end

    assign err_timeout = r_to;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_pop            = w_hit;
    assign err_timeout      = 1'b0;
`endif

    htree_rd_fifo #(
        .Depth (ReqDepth),
        .Width (LEAF_W)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (req_valid),
        .i_pop   (w_pop),
        .i_wdata (req_leaf),
        .o_rdata (w_head),
        .o_count (pending),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign req_ready      = ~w_full;
    assign data_out       = r_data;
    assign data_out_valid = r_dv;
    assign data_out_leaf  = r_leaf;
    assign err_collision  = r_col;
    assign err_unexpected = r_unx;

endmodule

// File: tb/tb_htree_read_return_16.sv
// Bench for htree_read_return_16: directed scenarios plus random traffic against a queue-based model.
module tb_htree_read_return_16;

    localparam int BW    = 32;
    localparam int DEPTH = 8;

    logic            CLK = 1'b0;
    logic            RST;
    logic            req_valid;
    logic [3:0]      req_leaf;
    logic            req_ready;
    logic [15:0]     rd_valid_sub;
    logic [16*BW-1:0] data_out_sub;
    logic [BW-1:0]   data_out;
    logic            data_out_valid;
    logic [3:0]      data_out_leaf;
    logic [3:0]      pending;
    logic            err_collision;
    logic            err_unexpected;
    logic            err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: pending leaves, two-deep return pipeline, expected outputs
    logic [3:0]       m_q [$];
    logic [15:0]      m_pv [$];
    logic [16*BW-1:0] m_pd [$];
    logic             exp_dv, exp_col, exp_unx;
    logic [BW-1:0]    exp_data;
    logic [3:0]       exp_leaf;

    always #5 CLK = ~CLK;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    htree_read_return_16 #(
        .BusWidth       (BW),
        .ReqDepth       (DEPTH),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .req_valid      (req_valid),
        .req_leaf       (req_leaf),
        .req_ready      (req_ready),
        .rd_valid_sub   (rd_valid_sub),
        .data_out_sub   (data_out_sub),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_leaf  (data_out_leaf),
        .pending        (pending),
        .err_collision  (err_collision),
        .err_unexpected (err_unexpected),
        .err_timeout    (err_timeout)
    );

    task automatic garbage();
        for (int i = 0; i < 16; i++) data_out_sub[i*BW +: BW] = $urandom();
    endtask

    task automatic idle();
        rd_valid_sub = '0;
        garbage();
    endtask

    // Non-returning leaves carry random data to exercise masking
    task automatic set_ret(input int leaf, input logic [BW-1:0] d);
        garbage();
        rd_valid_sub = '0;
        rd_valid_sub[leaf] = 1'b1;
        data_out_sub[leaf*BW +: BW] = d;
    endtask

    task automatic push(input logic [3:0] leaf);
        req_valid = 1'b1;
        req_leaf  = leaf;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pv.delete();
        m_pd.delete();
        repeat (2) begin
            m_pv.push_back('0);
            m_pd.push_back('0);
        end
        exp_dv = 0; exp_col = 0; exp_unx = 0; exp_data = '0; exp_leaf = '0;
    endtask

    // Advance one clock; the model resolves the return sampled two edges earlier
    task automatic tick();
        logic [15:0]      v;
        logic [16*BW-1:0] d;
        logic             rdy;
        int               leaf;
        m_pv.push_back(rd_valid_sub);
        m_pd.push_back(data_out_sub);
        v   = m_pv.pop_front();
        d   = m_pd.pop_front();
        rdy = (m_q.size() < DEPTH);
        exp_dv = 0; exp_col = 0; exp_unx = 0;
        if ($countones(v) > 1) begin
            exp_col = 1;
        end else if (v != 0) begin
            leaf = 0;
            for (int i = 0; i < 16; i++) if (v[i]) leaf = i;
            if (m_q.size() > 0 && m_q[0] == 4'(leaf)) begin
                exp_dv   = 1;
                exp_data = d[leaf*BW +: BW];
                exp_leaf = 4'(leaf);
                void'(m_q.pop_front());
            end else begin
                exp_unx = 1;
            end
        end
        if (req_valid && rdy) m_q.push_back(req_leaf);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 0;
        idle();
        RST = 1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 0;
        model_reset();
    endtask

    task automatic test_reset();
        req_valid = 0; req_leaf = 0;
        idle();
        RST = 1;
        #1;
        n_checks++;
        if (data_out_valid !== 1'b0 || data_out !== '0 || data_out_leaf !== 4'd0 ||
            err_collision !== 1'b0 || err_unexpected !== 1'b0 || err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got dv=%b d=%h l=%0d col=%b unx=%b to=%b want all 0",
                     data_out_valid, data_out, data_out_leaf, err_collision, err_unexpected,
                     err_timeout);
        end
        n_checks++;
        if (req_ready !== 1'b1 || pending !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_queue: got ready=%b pending=%0d want ready=1 pending=0",
                     req_ready, pending);
        end
        do_reset();
    endtask

    task automatic test_single();
        push(4'd5);
        n_checks++;
        if (pending !== 4'd1) begin
            n_fail++;
            $display("FAIL single_pending_push: got %0d want 1", pending);
        end
        set_ret(5, 32'hDEADBEEF);
        tick();
        idle();
        tick();
        n_checks++;
        if (data_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: got dv=%b want 0 at N+1", data_out_valid);
        end
        tick();
        n_checks++;
        if (data_out_valid !== 1'b1 || data_out !== 32'hDEADBEEF || data_out_leaf !== 4'd5) begin
            n_fail++;
            $display("FAIL single_return: got dv=%b d=%h l=%0d want dv=1 d=deadbeef l=5",
                     data_out_valid, data_out, data_out_leaf);
        end
        n_checks++;
        if (pending !== 4'd0) begin
            n_fail++;
            $display("FAIL single_pending_pop: got %0d want 0", pending);
        end
        tick();
        n_checks++;
        if (data_out_valid !== 1'b0 || data_out !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_hold: got dv=%b d=%h want dv=0 d=deadbeef",
                     data_out_valid, data_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [3];
        logic [3:0] got [$];
        seq[0] = 4'd3; seq[1] = 4'd12; seq[2] = 4'd0;
        for (int k = 0; k < 3; k++) push(seq[k]);
        for (int k = 0; k < 6; k++) begin
            if (k < 3) set_ret(seq[k], $urandom());
            else idle();
            tick();
            n_checks++;
            if (data_out_valid !== exp_dv || err_collision !== 1'b0 || err_unexpected !== 1'b0 ||
                (exp_dv && (data_out !== exp_data || data_out_leaf !== exp_leaf))) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got dv=%b d=%h l=%0d col=%b unx=%b want dv=%b d=%h l=%0d",
                         k, data_out_valid, data_out, data_out_leaf, err_collision,
                         err_unexpected, exp_dv, exp_data, exp_leaf);
            end
            if (data_out_valid === 1'b1) got.push_back(data_out_leaf);
        end
        n_checks++;
        if (got.size() != 3 || got[0] !== seq[0] || got[1] !== seq[1] || got[2] !== seq[2]) begin
            n_fail++;
            $display("FAIL b2b_order: got %0d pulses want 3 pulses with leaves 3,12,0", got.size());
        end
    endtask

    task automatic test_unexpected();
        push(4'd7);
        set_ret(6, $urandom());
        tick();
        idle();
        tick();
        tick();
        n_checks++;
        if (err_unexpected !== 1'b1 || data_out_valid !== 1'b0 || pending !== 4'd1) begin
            n_fail++;
            $display("FAIL unexpected_wrong_leaf: got unx=%b dv=%b pending=%0d want 1,0,1",
                     err_unexpected, data_out_valid, pending);
        end
        set_ret(7, 32'h0BADF00D);
        tick();
        idle();
        tick();
        tick();
        n_checks++;
        if (data_out_valid !== 1'b1 || data_out_leaf !== 4'd7 || data_out !== 32'h0BADF00D ||
            err_unexpected !== 1'b0 || pending !== 4'd0) begin
            n_fail++;
            $display("FAIL unexpected_recover: got dv=%b l=%0d d=%h unx=%b pending=%0d",
                     data_out_valid, data_out_leaf, data_out, err_unexpected, pending);
        end
        // Return with nothing outstanding
        set_ret(4, $urandom());
        tick();
        idle();
        tick();
        tick();
        n_checks++;
        if (err_unexpected !== 1'b1 || data_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL unexpected_empty: got unx=%b dv=%b want unx=1 dv=0",
                     err_unexpected, data_out_valid);
        end
    endtask

    task automatic test_collision();
        push(4'd2);
        push(4'd9);
        garbage();
        rd_valid_sub = 16'h0204;
        tick();
        idle();
        tick();
        tick();
        n_checks++;
        if (err_collision !== 1'b1 || data_out_valid !== 1'b0 || err_unexpected !== 1'b0 ||
            pending !== 4'd2) begin
            n_fail++;
            $display("FAIL collision_cross_group: got col=%b dv=%b unx=%b pending=%0d want 1,0,0,2",
                     err_collision, data_out_valid, err_unexpected, pending);
        end
        garbage();
        rd_valid_sub = 16'h000C;
        tick();
        idle();
        tick();
        tick();
        n_checks++;
        if (err_collision !== 1'b1 || data_out_valid !== 1'b0 || pending !== 4'd2) begin
            n_fail++;
            $display("FAIL collision_same_group: got col=%b dv=%b pending=%0d want 1,0,2",
                     err_collision, data_out_valid, pending);
        end
        set_ret(2, $urandom());
        tick();
        set_ret(9, $urandom());
        tick();
        idle();
        tick();
        tick();
        n_checks++;
        if (pending !== 4'd0 || data_out_leaf !== 4'd9 || err_collision !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_drain: got pending=%0d l=%0d col=%b want 0,9,0",
                     pending, data_out_leaf, err_collision);
        end
    endtask

    task automatic test_full();
        logic [3:0] lv [$];
        logic [3:0] x;
        for (int i = 0; i < DEPTH; i++) begin
            lv.push_back(4'($urandom_range(0, 15)));
            push(lv[i]);
        end
        n_checks++;
        if (req_ready !== 1'b0 || pending !== 4'd8) begin
            n_fail++;
            $display("FAIL full_flag: got ready=%b pending=%0d want 0,8", req_ready, pending);
        end
        push(4'($urandom_range(0, 15)));
        n_checks++;
        if (pending !== 4'd8 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ignore_push: got pending=%0d ready=%b want 8,0", pending, req_ready);
        end
        set_ret(lv[0], $urandom());
        tick();
        idle();
        tick();
        tick();
        n_checks++;
        if (pending !== 4'd7 || req_ready !== 1'b1 || data_out_valid !== 1'b1 ||
            data_out_leaf !== lv[0]) begin
            n_fail++;
            $display("FAIL full_pop: got pending=%0d ready=%b dv=%b l=%0d want 7,1,1,%0d",
                     pending, req_ready, data_out_valid, data_out_leaf, lv[0]);
        end
        // Pop and push resolve at the same edge
        x = 4'($urandom_range(0, 15));
        set_ret(lv[1], $urandom());
        tick();
        idle();
        tick();
        req_valid = 1'b1;
        req_leaf  = x;
        tick();
        req_valid = 1'b0;
        n_checks++;
        if (pending !== 4'd7 || data_out_valid !== 1'b1 || data_out_leaf !== lv[1]) begin
            n_fail++;
            $display("FAIL full_push_pop: got pending=%0d dv=%b l=%0d want 7,1,%0d",
                     pending, data_out_valid, data_out_leaf, lv[1]);
        end
        lv.push_back(x);
        for (int i = 2; i < lv.size(); i++) begin
            set_ret(lv[i], $urandom());
            tick();
            n_checks++;
            if (data_out_valid !== exp_dv || err_unexpected !== 1'b0) begin
                n_fail++;
                $display("FAIL full_drain%0d: got dv=%b unx=%b want dv=%b unx=0",
                         i, data_out_valid, err_unexpected, exp_dv);
            end
        end
        idle();
        tick();
        tick();
        n_checks++;
        if (pending !== 4'd0) begin
            n_fail++;
            $display("FAIL full_drained: got pending=%0d want 0", pending);
        end
    endtask

    task automatic test_random();
        int r, a, b;
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 4 && m_q.size() > 0) begin
                set_ret(int'(m_q[0]), $urandom());
            end else if (r == 5) begin
                set_ret($urandom_range(0, 15), $urandom());
            end else if (r == 6) begin
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                set_ret(a, $urandom());
                rd_valid_sub[b] = 1'b1;
            end else begin
                idle();
            end
            req_valid = ($urandom_range(0, 2) == 0);
            req_leaf  = 4'($urandom_range(0, 15));
            tick();
            n_checks++;
            if (data_out_valid !== exp_dv || err_collision !== exp_col ||
                err_unexpected !== exp_unx || data_out !== exp_data ||
                data_out_leaf !== exp_leaf || pending !== 4'(m_q.size()) ||
                req_ready !== (m_q.size() < DEPTH) || err_timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got dv=%b col=%b unx=%b d=%h l=%0d p=%0d rdy=%b want dv=%b col=%b unx=%b d=%h l=%0d p=%0d",
                         k, data_out_valid, err_collision, err_unexpected, data_out,
                         data_out_leaf, pending, req_ready, exp_dv, exp_col, exp_unx,
                         exp_data, exp_leaf, m_q.size());
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset_midop();
        do_reset();
        push(4'd10);
        push(4'd4);
        push(4'd14);
        set_ret(10, 32'h12345678);
        tick();
        idle();
        tick();
        tick();
        push(4'd1);
        n_checks++;
        if (pending !== 4'd3 || data_out !== 32'h12345678 || data_out_leaf !== 4'd10) begin
            n_fail++;
            $display("FAIL midop_setup: got pending=%0d d=%h l=%0d want 3,12345678,10",
                     pending, data_out, data_out_leaf);
        end
        set_ret(4, $urandom());
        tick();
        #2;
        RST = 1'b1;
        #1;
        n_checks++;
        if (data_out_valid !== 1'b0 || data_out !== '0 || data_out_leaf !== 4'd0 ||
            err_collision !== 1'b0 || err_unexpected !== 1'b0 || err_timeout !== 1'b0 ||
            req_ready !== 1'b1 || pending !== 4'd0) begin
            n_fail++;
            $display("FAIL midop_reset: got dv=%b d=%h l=%0d col=%b unx=%b rdy=%b p=%0d",
                     data_out_valid, data_out, data_out_leaf, err_collision, err_unexpected,
                     req_ready, pending);
        end
        idle();
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (data_out_valid !== 1'b0 || err_unexpected !== 1'b0 || err_collision !== 1'b0) begin
                n_fail++;
                $display("FAIL midop_flushed%0d: got dv=%b unx=%b col=%b want 0,0,0",
                         k, data_out_valid, err_unexpected, err_collision);
            end
        end
    endtask

    task automatic test_timeout();
        int pulses;
        pulses = 0;
        do_reset();
        push(4'd1);
`ifdef HTREE_RD_TIMEOUT_EN
        for (int k = 0; k < 200; k++) begin
            tick();
            if (err_timeout === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 1 || pending !== 4'd0) begin
            n_fail++;
            $display("FAIL timeout_fire: got pulses=%0d pending=%0d want 1,0", pulses, pending);
        end
`else
        for (int k = 0; k < 100; k++) begin
            tick();
            if (err_timeout !== 1'b0) pulses++;
        end
        n_checks++;
        if (pulses != 0 || pending !== 4'd1) begin
            n_fail++;
            $display("FAIL timeout_disabled: got pulses=%0d pending=%0d want 0,1", pulses, pending);
        end
`endif
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_unexpected();
        test_collision();
        test_full();
        test_random();
        test_reset_midop();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
